// File: rtl/regfile_dump_engine.sv
// rtl/regfile_dump_engine.sv - run/trace/dump controller streaming regfile writes and a final regfile dump
module regfile_dump_engine #(
    parameter int CYCLE_W  = 8,
    parameter int NUM_REGS = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [CYCLE_W-1:0] num_cycles,
    output logic               cpu_run,
    input  logic               rwe,
    input  logic [4:0]         rd,
    input  logic [31:0]        rData,
    output logic               test_mode,
    output logic [4:0]         test_reg,
    input  logic [31:0]        regA,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_kind,
    output logic [4:0]         out_index,
    output logic [31:0]        out_data,
    output logic [CYCLE_W-1:0] out_cycle,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_DRAIN, S_DUMP_SEL, S_DUMP_SEND, S_DONE
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t             state_q, state_d;
    logic [CYCLE_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CYCLE_W-1:0] num_q, num_d;
    logic [4:0]         idx_q, idx_d;
    logic               done_q, done_d;
    logic               out_valid_q, out_valid_d;
    logic               out_kind_q, out_kind_d;
    logic [4:0]         out_index_q, out_index_d;
    logic [31:0]        out_data_q, out_data_d;
    logic [CYCLE_W-1:0] out_cycle_q, out_cycle_d;
    logic               accept;

    assign accept = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        num_d       = num_q;
        idx_d       = idx_q;
        done_d      = done_q;
        out_valid_d = out_valid_q && !out_ready;
        out_kind_d  = out_kind_q;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;
        out_cycle_d = out_cycle_q;
        cpu_run     = 1'b0;
        test_mode   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cycle_cnt_d = '0;
                    num_d       = num_cycles;
                    idx_d       = '0;
                    done_d      = 1'b0;
                    state_d     = (num_cycles == '0) ? S_DUMP_SEL : S_RUN;
                end
            end
            S_RUN: begin
                // The processor only advances when the holding register can take a new record.
                cpu_run = !out_valid_q || out_ready;
                if (cpu_run) begin
                    if (rwe && rd != 5'd0) begin
                        out_valid_d = 1'b1;
                        out_kind_d  = 1'b0;
                        out_index_d = rd;
                        out_data_d  = rData;
                        out_cycle_d = cycle_cnt_q;
                    end
                    cycle_cnt_d = cycle_cnt_q + CYCLE_W'(1);
                    if (cycle_cnt_q == num_q - CYCLE_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!out_valid_q || out_ready) begin
                    idx_d   = '0;
                    state_d = S_DUMP_SEL;
                end
            end
            S_DUMP_SEL: begin
                test_mode   = 1'b1;
                out_valid_d = 1'b1;
                out_kind_d  = 1'b1;
                out_index_d = idx_q;
                out_data_d  = regA;
                out_cycle_d = cycle_cnt_q;
                state_d     = S_DUMP_SEND;
            end
            S_DUMP_SEND: begin
                test_mode = 1'b1;
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_DUMP_SEL;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cycle_cnt_q <= '0;
            num_q       <= '0;
            idx_q       <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_kind_q  <= 1'b0;
            out_index_q <= '0;
            out_data_q  <= '0;
            out_cycle_q <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            num_q       <= num_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_kind_q  <= out_kind_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            out_cycle_q <= out_cycle_d;
        end
    end

    assign test_reg  = test_mode ? idx_q : 5'd0;
    assign out_valid = out_valid_q;
    assign out_kind  = out_kind_q;
    assign out_index = out_index_q;
    assign out_data  = out_data_q;
    assign out_cycle = out_cycle_q;
    assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump_engine.sv
// tb/tb_regfile_dump_engine.sv - directed self-checking bench for regfile_dump_engine
module tb_regfile_dump_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  num_cycles;
    logic        cpu_run;
    logic        rwe;
    logic [4:0]  rd;
    logic [31:0] rData;
    logic        test_mode;
    logic [4:0]  test_reg;
    logic [31:0] regA;
    logic        out_valid;
    logic        out_ready;
    logic        out_kind;
    logic [4:0]  out_index;
    logic [31:0] out_data;
    logic [7:0]  out_cycle;
    logic        done;

    regfile_dump_engine #(.CYCLE_W(8), .NUM_REGS(32)) dut (
        .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
        .cpu_run(cpu_run), .rwe(rwe), .rd(rd), .rData(rData),
        .test_mode(test_mode), .test_reg(test_reg), .regA(regA),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_index(out_index), .out_data(out_data), .out_cycle(out_cycle), .done(done)
    );

    always #5 clock = ~clock;

    // Register file and processor write schedule model
    logic [31:0] regs [32];
    assign regA = regs[test_reg];
    bit          wr_en   [64];
    logic [4:0]  wr_rd   [64];
    logic [31:0] wr_data [64];

    logic        q_kind [$];
    logic [4:0]  q_idx  [$];
    logic [31:0] q_data [$];
    logic [7:0]  q_cyc  [$];

    int errors = 0;
    int checks = 0;
    int pulses, viol, tmbad, proc_cycle;
    bit timed_out;

    task automatic clear_sched();
        for (int i = 0; i < 64; i++) begin
            wr_en[i] = 1'b0; wr_rd[i] = 5'd0; wr_data[i] = 32'd0;
        end
    endtask

    task automatic start_run(input logic [7:0] n);
        @(negedge clock);
        start = 1'b1; num_cycles = n; out_ready = 1'b1; rwe = 1'b0;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // mode 0: ready always 1; 1: ready toggles; 2: ready low 4 cycles after first record
    task automatic run_session(input int mode, input int start_at, input logic [7:0] start_n);
        int cyc; int stall_left; bit first_seen; bit run_now;
        cyc = 0; stall_left = 0; first_seen = 0;
        pulses = 0; viol = 0; tmbad = 0; timed_out = 0; proc_cycle = 0;
        q_kind.delete(); q_idx.delete(); q_data.delete(); q_cyc.delete();
        forever begin
            @(negedge clock);
            start = (cyc == start_at);
            if (cyc == start_at) num_cycles = start_n;
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 1) out_ready = (cyc % 2 == 0);
            else begin
                if (!first_seen && out_valid) begin first_seen = 1; stall_left = 4; end
                if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
                else out_ready = 1'b1;
            end
            if (proc_cycle < 64 && wr_en[proc_cycle]) begin
                rwe = 1'b1; rd = wr_rd[proc_cycle]; rData = wr_data[proc_cycle];
            end else begin
                rwe = 1'b0; rd = 5'd0; rData = 32'd0;
            end
            #1;
            if (done) break;
            if (out_valid && out_ready) begin
                q_kind.push_back(out_kind); q_idx.push_back(out_index);
                q_data.push_back(out_data); q_cyc.push_back(out_cycle);
            end
            if (out_valid && !out_ready && cpu_run) viol++;
            if (out_valid && out_kind && (test_reg !== out_index || !test_mode)) tmbad++;
            run_now = cpu_run;
            @(posedge clock);
            if (run_now) begin
                pulses++;
                if (rwe && rd != 5'd0) regs[rd] = rData;
                proc_cycle++;
            end
            cyc++;
            if (cyc > 2000) begin timed_out = 1; break; end
        end
        start = 1'b0; rwe = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; num_cycles = 8'd0; rwe = 1'b0; rd = 5'd0;
        rData = 32'd0; out_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        clear_sched();
        #12;
        checks++;
        if ({cpu_run, test_mode, test_reg, out_valid, out_kind, out_index, out_data, out_cycle, done} !== 80'd0)
            begin errors++; $display("FAIL reset_outputs: got %h required 0",
                {cpu_run, test_mode, test_reg, out_valid, out_kind, out_index, out_data, out_cycle, done}); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_basic_run();
        int bad;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        clear_sched();
        wr_en[1] = 1; wr_rd[1] = 5'd3; wr_data[1] = 32'd7;
        wr_en[2] = 1; wr_rd[2] = 5'd0; wr_data[2] = 32'd9;
        start_run(8'd5);
        run_session(0, -1, 8'd0);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: done not seen"); end
        checks++; if (pulses !== 5) begin errors++; $display("FAIL basic_pulses: got %0d required 5", pulses); end
        checks++;
        if (q_kind.size() !== 33) begin errors++; $display("FAIL basic_count: got %0d required 33", q_kind.size()); end
        else begin
            checks++;
            if ({q_kind[0], q_idx[0], q_data[0], q_cyc[0]} !== {1'b0, 5'd3, 32'd7, 8'd1}) begin
                errors++; $display("FAIL basic_trace: got k=%0d i=%0d d=%0d c=%0d required 0/3/7/1",
                    q_kind[0], q_idx[0], q_data[0], q_cyc[0]);
            end
            bad = 0;
            for (int i = 0; i < 32; i++)
                if (q_kind[i+1] !== 1'b1 || q_idx[i+1] !== 5'(i) || q_cyc[i+1] !== 8'd5 ||
                    q_data[i+1] !== ((i == 3) ? 32'd7 : 32'd0)) bad++;
            checks++; if (bad !== 0) begin errors++; $display("FAIL basic_dump: %0d bad records required 0", bad); end
        end
        checks++; if (test_mode !== 1'b0 || cpu_run !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL basic_done: tm=%0d run=%0d done=%0d required 0/0/1", test_mode, cpu_run, done); end
    endtask

    task automatic test_stall();
        int bad;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        clear_sched();
        for (int c = 0; c < 3; c++) begin wr_en[c] = 1; wr_rd[c] = 5'd1; wr_data[c] = 32'hA0 + 32'(c); end
        start_run(8'd4);
        run_session(2, -1, 8'd0);
        checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout: done not seen"); end
        checks++; if (pulses !== 4) begin errors++; $display("FAIL stall_pulses: got %0d required 4", pulses); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL stall_cpu_run: %0d stalled edges with cpu_run high required 0", viol); end
        checks++;
        if (q_kind.size() !== 35) begin errors++; $display("FAIL stall_count: got %0d required 35", q_kind.size()); end
        else begin
            bad = 0;
            for (int c = 0; c < 3; c++)
                if (q_kind[c] !== 1'b0 || q_idx[c] !== 5'd1 || q_data[c] !== 32'hA0 + 32'(c) || q_cyc[c] !== 8'(c)) bad++;
            checks++; if (bad !== 0) begin errors++; $display("FAIL stall_traces: %0d bad traces required 0", bad); end
            bad = 0;
            for (int i = 0; i < 32; i++)
                if (q_kind[i+3] !== 1'b1 || q_idx[i+3] !== 5'(i) || q_cyc[i+3] !== 8'd4 ||
                    q_data[i+3] !== ((i == 1) ? 32'hA2 : 32'd0)) bad++;
            checks++; if (bad !== 0) begin errors++; $display("FAIL stall_dump: %0d bad records required 0", bad); end
        end
    endtask

    task automatic test_zero_cycles();
        int bad;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i + 100);
        clear_sched();
        wr_en[0] = 1; wr_rd[0] = 5'd4; wr_data[0] = 32'h1234;
        start_run(8'd0);
        run_session(0, -1, 8'd0);
        checks++; if (timed_out) begin errors++; $display("FAIL zero_timeout: done not seen"); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL zero_pulses: got %0d required 0", pulses); end
        checks++;
        if (q_kind.size() !== 32) begin errors++; $display("FAIL zero_count: got %0d required 32", q_kind.size()); end
        else begin
            bad = 0;
            for (int i = 0; i < 32; i++)
                if (q_kind[i] !== 1'b1 || q_idx[i] !== 5'(i) || q_cyc[i] !== 8'd0 || q_data[i] !== 32'(i + 100)) bad++;
            checks++; if (bad !== 0) begin errors++; $display("FAIL zero_dump: %0d bad records required 0", bad); end
        end
    endtask

    task automatic test_toggle_dump();
        int bad;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);
        clear_sched();
        start_run(8'd1);
        run_session(1, -1, 8'd0);
        checks++; if (timed_out) begin errors++; $display("FAIL toggle_timeout: done not seen"); end
        checks++; if (tmbad !== 0) begin errors++; $display("FAIL toggle_test_reg: %0d mismatches required 0", tmbad); end
        checks++;
        if (q_kind.size() !== 32) begin errors++; $display("FAIL toggle_count: got %0d required 32", q_kind.size()); end
        else begin
            bad = 0;
            for (int i = 0; i < 32; i++)
                if (q_kind[i] !== 1'b1 || q_idx[i] !== 5'(i) || q_cyc[i] !== 8'd1 || q_data[i] !== 32'(i * 3)) bad++;
            checks++; if (bad !== 0) begin errors++; $display("FAIL toggle_dump: %0d bad records required 0", bad); end
        end
        checks++; if (test_mode !== 1'b0) begin errors++; $display("FAIL toggle_test_mode: got %0d required 0", test_mode); end
    endtask

    task automatic test_reset_mid_dump();
        int n; int bad; bit hit;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);
        clear_sched();
        start_run(8'd0);
        hit = 0;
        for (n = 0; n < 200; n++) begin
            @(negedge clock);
            out_ready = 1'b1;
            #1;
            if (out_valid && out_index == 5'd10) begin out_ready = 1'b0; hit = 1; break; end
        end
        checks++; if (!hit) begin errors++; $display("FAIL rst_reach_idx10: not reached"); end
        checks++; if (out_data !== 32'd30) begin errors++; $display("FAIL rst_idx10_data: got %0d required 30", out_data); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({cpu_run, test_mode, test_reg, out_valid, out_kind, out_index, out_data, out_cycle, done} !== 80'd0)
            begin errors++; $display("FAIL rst_async_outputs: got %h required 0",
                {cpu_run, test_mode, test_reg, out_valid, out_kind, out_index, out_data, out_cycle, done}); end
        @(negedge clock);
        reset = 1'b1;
        wr_en[1] = 1; wr_rd[1] = 5'd5; wr_data[1] = 32'h55;
        start_run(8'd2);
        run_session(0, -1, 8'd0);
        checks++; if (pulses !== 2) begin errors++; $display("FAIL rst_rerun_pulses: got %0d required 2", pulses); end
        checks++;
        if (q_kind.size() !== 33) begin errors++; $display("FAIL rst_rerun_count: got %0d required 33", q_kind.size()); end
        else begin
            bad = 0;
            if ({q_kind[0], q_idx[0], q_data[0], q_cyc[0]} !== {1'b0, 5'd5, 32'h55, 8'd1}) bad++;
            for (int i = 0; i < 32; i++)
                if (q_kind[i+1] !== 1'b1 || q_idx[i+1] !== 5'(i) || q_cyc[i+1] !== 8'd2 ||
                    q_data[i+1] !== ((i == 5) ? 32'h55 : 32'(i * 3))) bad++;
            checks++; if (bad !== 0) begin errors++; $display("FAIL rst_rerun_records: %0d bad records required 0", bad); end
        end
    endtask

    task automatic test_start_ignore_restart();
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        clear_sched();
        start_run(8'd6);
        run_session(0, 2, 8'd2);
        checks++; if (pulses !== 6) begin errors++; $display("FAIL ignore_pulses: got %0d required 6", pulses); end
        checks++;
        if (q_cyc.size() !== 32) begin errors++; $display("FAIL ignore_count: got %0d required 32", q_cyc.size()); end
        else begin
            checks++; if (q_cyc[31] !== 8'd6) begin errors++; $display("FAIL ignore_cycle: got %0d required 6", q_cyc[31]); end
        end
        start_run(8'd3);
        checks++; if (done !== 1'b0 || cpu_run !== 1'b1) begin
            errors++; $display("FAIL restart_edge: done=%0d run=%0d required 0/1", done, cpu_run); end
        run_session(0, -1, 8'd0);
        checks++; if (pulses !== 3 || timed_out) begin
            errors++; $display("FAIL restart_pulses: got %0d timeout=%0d required 3/0", pulses, timed_out); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done: got %0d required 1", done); end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_stall();
        test_zero_cycles();
        test_toggle_dump();
        test_reset_mid_dump();
        test_start_ignore_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
